// File: rtl/garage_occupancy_counter_pkg.sv
// Shared types for the garage occupancy path: lane FSM encoding and count width
// (the count width is also consumed by the 7-segment display stage).
package garage_occupancy_counter_pkg;

  localparam int COUNT_W = 6;

  typedef enum logic [1:0] {
    LANE_IDLE     = 2'd0,
    LANE_DEBOUNCE = 2'd1,
    LANE_PRESENT  = 2'd2,
    LANE_RELEASE  = 2'd3
  } lane_state_t;

endpackage

// File: rtl/garage_occupancy_counter_lane_detector.sv
// One sensor lane: 2-FF synchronizer, debounce FSM, one registered detect per car.
//
// state          | meaning
// LANE_IDLE      | no car, waiting for presence
// LANE_DEBOUNCE  | presence seen, waiting for it to be stable
// LANE_PRESENT   | car accepted, detect already issued
// LANE_RELEASE   | presence gone, waiting for absence to be stable
module lane_detector
  import garage_occupancy_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  output logic detect,
  output logic lane_idle
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_ff;
  logic             sync;
  lane_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             detect_nxt;

  assign sync = sync_ff[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff <= 2'b00;
      state   <= LANE_IDLE;
      cnt     <= '0;
      detect  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], sensor};
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      detect  <= detect_nxt;
    end
  end

  // Down-counter: loading D-1 and terminating at zero accepts on the same
  // sample as counting 1..D upward.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    detect_nxt = 1'b0;
    unique case (state)
      LANE_IDLE: begin
        if (sync) begin
          state_nxt = LANE_DEBOUNCE;
          cnt_nxt   = CNT_LOAD;
        end
      end
      LANE_DEBOUNCE: begin
        if (!sync) begin
          state_nxt = LANE_IDLE;
        end else if (cnt == '0) begin
          state_nxt  = LANE_PRESENT;
          detect_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      LANE_PRESENT: begin
        if (!sync) begin
          state_nxt = LANE_RELEASE;
          cnt_nxt   = CNT_LOAD;
        end
      end
      LANE_RELEASE: begin
        if (sync) begin
          state_nxt = LANE_PRESENT;
        end else if (cnt == '0) begin
          state_nxt = LANE_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = LANE_IDLE;
    endcase
  end

  always_comb begin
    lane_idle = (state == LANE_IDLE);
  end

endmodule

// File: rtl/garage_occupancy_counter.sv
// Garage occupancy: two debounced lanes drive a saturating car count, the
// full/empty flags and the entry/exit gate commands.
module garage_occupancy_counter
  import garage_occupancy_counter_pkg::*;
#(
  parameter int CAPACITY        = 40,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               entry_sensor,
  input  logic               exit_sensor,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty,
  output logic               entry_gate_open,
  output logic               exit_gate_open,
  output logic               entry_denied,
  output logic               exit_error
);

  localparam logic [COUNT_W-1:0] CAP = COUNT_W'(CAPACITY);

  logic               edet, xdet, entry_idle, exit_idle;
  logic [COUNT_W-1:0] count_nxt;
  logic               denied_nxt, error_nxt, egate_set, xgate_set;

  lane_detector #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_lane (
    .clk       (clk),
    .reset     (reset),
    .sensor    (entry_sensor),
    .detect    (edet),
    .lane_idle (entry_idle)
  );

  lane_detector #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_lane (
    .clk       (clk),
    .reset     (reset),
    .sensor    (exit_sensor),
    .detect    (xdet),
    .lane_idle (exit_idle)
  );

  // Simultaneous entry+exit nets to zero except from empty, where the exit is
  // the error case and the entry still lands.
  always_comb begin
    count_nxt  = count;
    denied_nxt = 1'b0;
    error_nxt  = 1'b0;
    egate_set  = 1'b0;
    xgate_set  = 1'b0;
    unique case ({edet, xdet})
      2'b10: begin
        if (count != CAP) begin
          count_nxt = count + 1'b1;
          egate_set = 1'b1;
        end else begin
          denied_nxt = 1'b1;
        end
      end
      2'b01: begin
        xgate_set = 1'b1;
        if (count != '0) count_nxt = count - 1'b1;
        else             error_nxt = 1'b1;
      end
      2'b11: begin
        egate_set = 1'b1;
        xgate_set = 1'b1;
        if (count == '0) begin
          count_nxt = COUNT_W'(1);
          error_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count           <= '0;
      full            <= 1'b0;
      empty           <= 1'b1;
      entry_gate_open <= 1'b0;
      exit_gate_open  <= 1'b0;
      entry_denied    <= 1'b0;
      exit_error      <= 1'b0;
    end else begin
      count        <= count_nxt;
      full         <= (count_nxt == CAP);
      empty        <= (count_nxt == '0);
      entry_denied <= denied_nxt;
      exit_error   <= error_nxt;
      if (egate_set)       entry_gate_open <= 1'b1;
      else if (entry_idle) entry_gate_open <= 1'b0;
      if (xgate_set)       exit_gate_open <= 1'b1;
      else if (exit_idle)  exit_gate_open <= 1'b0;
    end
  end

endmodule

// File: tb/tb_garage_occupancy_counter.sv
// Directed bench for garage_occupancy_counter with a per-cycle behavioural model.
module tb_garage_occupancy_counter;

  localparam int CAP = 3;
  localparam int D   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       entry_sensor = 1'b0;
  logic       exit_sensor = 1'b0;
  logic [5:0] count;
  logic       full, empty, entry_gate_open, exit_gate_open, entry_denied, exit_error;

  int vectors = 0;
  int miscompares = 0;

  garage_occupancy_counter #(.CAPACITY(CAP), .DEBOUNCE_CYCLES(D)) dut (
    .clk             (clk),
    .reset           (reset),
    .entry_sensor    (entry_sensor),
    .exit_sensor     (exit_sensor),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .entry_gate_open (entry_gate_open),
    .exit_gate_open  (exit_gate_open),
    .entry_denied    (entry_denied),
    .exit_error      (exit_error)
  );

  always #5 clk = ~clk;

  // Model: a lane's accepted level flips after D+1 consecutive synchronized
  // samples disagreeing with it; a rise to 1 is one car.
  int m_count = 0;
  bit m_eg = 0, m_xg = 0, m_den = 0, m_err = 0;
  bit m_s1[2], m_s2[2], m_lvl[2], m_det[2];
  int m_run[2];
  bit e_in, x_in, ie, ix, eacc, xacc;
  bit raw[2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count = 0; m_eg = 0; m_xg = 0; m_den = 0; m_err = 0;
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_det[i] = 0; m_run[i] = 0;
      end
    end else begin
      e_in = m_det[0];
      x_in = m_det[1];
      ie = !m_lvl[0] && (m_run[0] == 0);
      ix = !m_lvl[1] && (m_run[1] == 0);
      m_den = 0; m_err = 0; eacc = 0; xacc = x_in;
      if (e_in && x_in) begin
        eacc = 1;
        if (m_count == 0) begin m_count = 1; m_err = 1; end
      end else if (e_in) begin
        if (m_count < CAP) begin m_count++; eacc = 1; end
        else m_den = 1;
      end else if (x_in) begin
        if (m_count > 0) m_count--;
        else m_err = 1;
      end
      if (eacc) m_eg = 1; else if (ie) m_eg = 0;
      if (xacc) m_xg = 1; else if (ix) m_xg = 0;
      raw[0] = entry_sensor;
      raw[1] = exit_sensor;
      for (int i = 0; i < 2; i++) begin
        m_det[i] = 0;
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_lvl[i] = m_s2[i];
            m_run[i] = 0;
            m_det[i] = m_s2[i];
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
  end

  int den_seen = 0, err_seen = 0, eg_seen = 0, xg_seen = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (entry_denied)    den_seen++;
      if (exit_error)      err_seen++;
      if (entry_gate_open) eg_seen++;
      if (exit_gate_open)  xg_seen++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pass(input bit e, input bit x, input int hold);
    tick(1);
    entry_sensor = e;
    exit_sensor  = x;
    tick(hold);
    entry_sensor = 0;
    exit_sensor  = 0;
    tick(14);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 reset = 1;
    #1;
    check("reset_count", int'(count), 0);
    check("reset_flags", int'({full, empty}), 1);
    check("reset_gates", int'({entry_gate_open, exit_gate_open}), 0);
    entry_sensor = 0;
    exit_sensor  = 0;
    @(negedge clk);
    reset = 0;
    tick(1);
  endtask

  logic [11:0] act_v, exp_v;
  int d0, e0, g0, h0;

  initial begin
    fork
      forever begin
        @(negedge clk);
        act_v = {count, full, empty, entry_gate_open, exit_gate_open, entry_denied, exit_error};
        exp_v = {6'(m_count), m_count == CAP, m_count == 0, m_eg, m_xg, m_den, m_err};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL model_cycle: got %b, expected %b at %0t", act_v, exp_v, $time);
        end
      end
    join_none

    reset = 1;
    #23 reset = 0;
    check("post_reset_count", int'(count), 0);
    check("post_reset_empty", int'(empty), 1);

    // single entry, timing of count and gate
    tick(1);
    entry_sensor = 1;
    tick(7);
    check("entry_edge7_count", int'(count), 0);
    tick(1);
    check("entry_edge8_count", int'(count), 1);
    check("entry_edge8_gate", int'(entry_gate_open), 1);
    tick(12);
    entry_sensor = 0;
    tick(7);
    check("gate_still_open", int'(entry_gate_open), 1);
    tick(1);
    check("gate_closed", int'(entry_gate_open), 0);
    check("single_increment", int'(count), 1);

    // glitch of 3 cycles
    entry_sensor = 1;
    tick(3);
    entry_sensor = 0;
    tick(14);
    check("glitch_count", int'(count), 1);

    // fill to capacity, then a denied fourth car
    pass(1, 0, 10);
    pass(1, 0, 10);
    check("full_count", int'(count), 3);
    check("full_flag", int'(full), 1);
    d0 = den_seen; g0 = eg_seen;
    pass(1, 0, 10);
    check("denied_pulses", den_seen - d0, 1);
    check("denied_count", int'(count), 3);
    check("denied_gate_cycles", eg_seen - g0, 0);

    // exit in progress, then reset mid-cycle with the exit gate open
    tick(1);
    exit_sensor = 1;
    tick(8);
    check("exit_count", int'(count), 2);
    check("exit_gate", int'(exit_gate_open), 1);
    mid_reset();

    // both lanes at count 0
    e0 = err_seen;
    pass(1, 1, 10);
    check("both_at_zero_count", int'(count), 1);
    check("both_at_zero_err", err_seen - e0, 1);
    pass(1, 0, 10);
    check("count_two", int'(count), 2);

    // both lanes at count 2
    g0 = eg_seen; h0 = xg_seen; e0 = err_seen;
    pass(1, 1, 10);
    check("both_at_two_count", int'(count), 2);
    check("both_gates_opened", int'((eg_seen > g0) && (xg_seen > h0)), 1);
    check("both_at_two_no_err", err_seen - e0, 0);

    // exit from empty
    mid_reset();
    e0 = err_seen; h0 = xg_seen;
    pass(0, 1, 10);
    check("empty_exit_err", err_seen - e0, 1);
    check("empty_exit_count", int'(count), 0);
    check("empty_exit_gate_seen", int'(xg_seen > h0), 1);
    check("empty_exit_gate_released", int'(exit_gate_open), 0);

    // bouncing car: short drops while present
    tick(1);
    entry_sensor = 1;
    tick(10);
    for (int k = 0; k < 3; k++) begin
      entry_sensor = 0;
      tick(2);
      entry_sensor = 1;
      tick(3);
    end
    entry_sensor = 0;
    tick(14);
    check("bounce_one_event", int'(count), 1);
    check("bounce_gate_closed", int'(entry_gate_open), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
